mem_arbiter_top: RTL and testbench
==================================

Name: mem_arbiter_top

Overview:
- Parametrised successor to the single-core processor-plus-memory top level.
- Shares one unified word-addressed memory among NCH requester channels through a round-robin arbiter with configurable wait states.
- Used as the memory side of multi-core or multi-master builds; exposes the granted write strobe, address and data for testbench checking.

Parameters:
- NCH, 2, number of requester channels (1..8).
- XLEN, 32, data and address width in bits.
- DEPTH, 64, memory depth in XLEN-bit words (power of two).
- LAT, 1, access wait states (1..7).

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- req  input  NCH  per-channel request; held high until that channel's ack.
- we  input  NCH  per-channel write enable; sampled with req.
- addr  input  NCH*XLEN  per-channel byte address; channel i occupies bits [i*XLEN +: XLEN].
- wdata  input  NCH*XLEN  per-channel write data; same packing as addr.
- ack  output  NCH  one-hot, single-cycle completion pulse.
- rdata  output  XLEN  shared read data; valid while the ack of a read is high.
- busy  output  1  high from the cycle after acceptance through the ACK cycle.
- MemWrite  output  1  memory write strobe (observation).
- DataAdr  output  XLEN  latched address of the current or last transaction.
- WriteData  output  XLEN  latched write data of the current or last transaction.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, ack=0, rdata=0, busy=0, MemWrite=0, DataAdr=0, WriteData=0, round-robin pointer=NCH-1 so channel 0 wins first. Memory contents are not reset.
- FSM has three states: IDLE, ACCESS, ACK.
- IDLE, no req: stay in IDLE.
- IDLE, any req high: grant the first requesting channel searching upward from pointer+1 modulo NCH. Latch the channel index, we, addr and wdata into ch/DataAdr/WriteData. Load cnt=LAT-1. Go to ACCESS.
- ACCESS, cnt!=0: decrement cnt.
- ACCESS, cnt==0 with latched we=1:
  - MemWrite=1 (combinational) during this cycle.
  - At the edge, mem[idx]<=WriteData.
  - Go to ACK.
- ACCESS, cnt==0 with latched we=0: at the edge, rdata<=mem[idx]; go to ACK.
- ACK: ack[ch]=1 for exactly one cycle; pointer<=ch; next state IDLE.
- Latency: ack is high in the (LAT+1)th cycle after the acceptance edge. Back-to-back transactions complete every LAT+2 cycles.
- Index rule: idx=DataAdr[log2(DEPTH)+1:2].
  - Bits [1:0] are ignored (word access only).
  - Upper bits are ignored, so addresses alias modulo 4*DEPTH.
- Write semantics: a write to the same word followed by a read of it returns the new data. rdata is updated only by reads and holds its value across writes and idle cycles.
- Inputs are sampled only at the acceptance edge. Changes to addr, wdata or we while a transaction is pending have no effect.
- req from a non-granted channel stays pending. It is arbitrated in the next IDLE cycle and is never dropped.
- Simultaneous requests are served strictly round-robin. With all NCH requesting continuously, each channel is served once per NCH transactions.
- req deasserted before ack: the transaction still completes and ack still pulses.
- Reset asserted mid-transaction:
  - Aborts immediately; outputs take reset values.
  - A write whose final edge had not occurred is not performed.
  - No ack is issued.
- NCH=1: the arbiter degenerates to a pass-through with identical timing.

Test Plan:
- Reset release with no req -> ack=0, busy=0, MemWrite=0, rdata=0 indefinitely.
- LAT=1, ch0 writes 0xDEADBEEF to 0x10, then reads 0x10 -> write ack at cycle 2 after acceptance with MemWrite=1 one cycle earlier and DataAdr=0x10; read ack with rdata=0xDEADBEEF.
- NCH=2, both channels request at the same edge after reset -> ch0 acked first, ch1 next. With both held continuously the ack order is 0,1,0,1.
- LAT=3 read -> ack exactly 4 cycles after acceptance; busy high for 4 cycles; ch1's address change during ACCESS does not affect rdata.
- DEPTH=64: write 0x55 to 0x000, read 0x100 and 0x003 -> both return 0x55 (aliasing and ignored low bits).
- Reset pulsed low during ACCESS of a write of 0x1234 to 0x20 -> no ack. After a subsequent read of 0x20, the prior contents are returned, not 0x1234.

Source files
------------

// File: rtl/mem_arbiter_top.sv
// -----------------------------------------------------------------------------
// mem_arbiter_top
//
// Purpose:
//   Shares one unified, word-addressed memory among NCH requester channels.
//   A round-robin arbiter picks one pending request while idle. The request is
//   held for LAT wait states and then completes with a single-cycle, one-hot
//   ack on the granted channel. For observation, the granted write strobe,
//   address and write data are exposed.
//
// Parameters:
//   NCH    number of requester channels (1..8)
//   XLEN   data and address width in bits
//   DEPTH  memory depth in XLEN-bit words (power of two, >= 2)
//   LAT    access wait states (1..7)
//
// Ports:
//   clk        clock; all state updates on the rising edge
//   reset      asynchronous, active-low reset
//   req        per-channel request, held until that channel's ack
//   we         per-channel write enable, sampled together with req
//   addr       per-channel byte address, channel i at [i*XLEN +: XLEN]
//   wdata      per-channel write data, same packing as addr
//   ack        one-hot, single-cycle completion pulse
//   rdata      shared read data; valid while the ack of a read is high
//   busy       high from the cycle after acceptance through the ACK cycle
//   MemWrite   memory write strobe
//   DataAdr    latched address of the current or last transaction
//   WriteData  latched write data of the current or last transaction
// -----------------------------------------------------------------------------
module mem_arbiter_top #(
  parameter int NCH   = 2,
  parameter int XLEN  = 32,
  parameter int DEPTH = 64,
  parameter int LAT   = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NCH-1:0]       req,
  input  logic [NCH-1:0]       we,
  input  logic [NCH*XLEN-1:0]  addr,
  input  logic [NCH*XLEN-1:0]  wdata,
  output logic [NCH-1:0]       ack,
  output logic [XLEN-1:0]      rdata,
  output logic                 busy,
  output logic                 MemWrite,
  output logic [XLEN-1:0]      DataAdr,
  output logic [XLEN-1:0]      WriteData
);

  // A channel index needs at least one bit, even when NCH is 1.
  localparam int CW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_ACK    = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   ch_q, ch_d;
  logic [CW-1:0]   ptr_q, ptr_d;
  logic [2:0]      cnt_q, cnt_d;
  logic            we_q, we_d;
  logic [XLEN-1:0] adr_q, adr_d;
  logic [XLEN-1:0] wd_q, wd_d;
  logic [XLEN-1:0] rdata_q, rdata_d;
  logic            mem_we;

  logic [XLEN-1:0] mem [DEPTH];
  logic [AW-1:0]   idx;

  logic [XLEN-1:0] addr_ch  [NCH];
  logic [XLEN-1:0] wdata_ch [NCH];

  logic            grant_valid;
  logic [CW-1:0]   grant_idx;

  // Unpack the per-channel buses and build the one-hot ack.
  for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
    assign addr_ch[gi]  = addr[gi*XLEN +: XLEN];
    assign wdata_ch[gi] = wdata[gi*XLEN +: XLEN];
    assign ack[gi]      = (state_q == S_ACK) && (ch_q == CW'(gi));
  end

  // Word index: byte-offset bits dropped, upper bits ignored (aliasing).
  assign idx = adr_q[AW+1:2];

  // Round-robin search starting at ptr+1 (mod NCH). The loop runs from the
  // farthest offset down to the nearest, so the nearest requester wins.
  always_comb begin
    int c;
    c           = 0;
    grant_valid = 1'b0;
    grant_idx   = '0;
    for (int k = NCH; k >= 1; k--) begin
      c = int'(ptr_q) + k;
      if (c >= NCH) begin
        c = c - NCH;
      end
      if (req[CW'(c)]) begin
        grant_valid = 1'b1;
        grant_idx   = CW'(c);
      end
    end
  end

  // Next-state and datapath logic.
  always_comb begin
    state_d = state_q;
    ch_d    = ch_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    adr_d   = adr_q;
    wd_d    = wd_q;
    rdata_d = rdata_q;
    mem_we  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (grant_valid) begin
          // Inputs are captured only here, so later changes are ignored.
          ch_d    = grant_idx;
          we_d    = we[grant_idx];
          adr_d   = addr_ch[grant_idx];
          wd_d    = wdata_ch[grant_idx];
          cnt_d   = 3'(LAT - 1);
          state_d = S_ACCESS;
        end
      end
      S_ACCESS: begin
        if (cnt_q != 3'd0) begin
          cnt_d = cnt_q - 3'd1;
        end else begin
          if (we_q) begin
            mem_we = 1'b1;
          end else begin
            rdata_d = mem[idx];
          end
          state_d = S_ACK;
        end
      end
      S_ACK: begin
        // Pointer moves only on completion, so an aborted grant never
        // advances the rotation.
        ptr_d   = ch_q;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      ch_q    <= '0;
      ptr_q   <= CW'(NCH - 1);
      cnt_q   <= '0;
      we_q    <= 1'b0;
      adr_q   <= '0;
      wd_q    <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      ch_q    <= ch_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      adr_q   <= adr_d;
      wd_q    <= wd_d;
      rdata_q <= rdata_d;
    end
  end

  // Memory contents are deliberately not reset. A reset forces the state to
  // IDLE asynchronously, which kills mem_we before the final write edge.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[idx] <= wd_q;
    end
  end

  assign rdata     = rdata_q;
  assign busy      = (state_q != S_IDLE);
  assign MemWrite  = mem_we;
  assign DataAdr   = adr_q;
  assign WriteData = wd_q;

endmodule

// File: tb/tb_mem_arbiter_top.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter_top
//
// Scoreboard bench for mem_arbiter_top (NCH=3, XLEN=32, DEPTH=64, LAT=3).
//
// The reference model works at the transaction level:
//   - An acceptance can occur at edge t only if t >= the previous acceptance
//     plus LAT+2. At that edge, the winner is the first requesting channel
//     after the last served one.
//   - The memory is a plain array, updated at acceptance.
//   - The expected ack cycle is t+LAT.
//
// A monitor checks ack, busy, MemWrite, rdata, DataAdr and WriteData on
// every falling edge against the transaction at the queue head.
// -----------------------------------------------------------------------------
module tb_mem_arbiter_top;

  localparam int NCH   = 3;
  localparam int XLEN  = 32;
  localparam int DEPTH = 64;
  localparam int LAT   = 3;

  logic                clk;
  logic                reset;
  logic [NCH-1:0]      req_v;
  logic [NCH-1:0]      we_v;
  logic [XLEN-1:0]     addr_ch [NCH];
  logic [XLEN-1:0]     wd_ch   [NCH];
  logic [NCH*XLEN-1:0] addr_bus;
  logic [NCH*XLEN-1:0] wdata_bus;
  logic [NCH-1:0]      ack;
  logic [XLEN-1:0]     rdata;
  logic                busy;
  logic                MemWrite;
  logic [XLEN-1:0]     DataAdr;
  logic [XLEN-1:0]     WriteData;

  mem_arbiter_top #(
    .NCH(NCH), .XLEN(XLEN), .DEPTH(DEPTH), .LAT(LAT)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .req      (req_v),
    .we       (we_v),
    .addr     (addr_bus),
    .wdata    (wdata_bus),
    .ack      (ack),
    .rdata    (rdata),
    .busy     (busy),
    .MemWrite (MemWrite),
    .DataAdr  (DataAdr),
    .WriteData(WriteData)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    addr_bus  = '0;
    wdata_bus = '0;
    for (int i = 0; i < NCH; i++) begin
      addr_bus[i*XLEN +: XLEN]  = addr_ch[i];
      wdata_bus[i*XLEN +: XLEN] = wd_ch[i];
    end
  end

  typedef struct {
    int              ch;
    logic            w;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] d;
    logic [XLEN-1:0] rd;
    logic [XLEN-1:0] old;
    int              idx;
    int              acc;
    int              ackc;
  } txn_t;

  txn_t            exp_q[$];
  logic [XLEN-1:0] mem_m [DEPTH];
  logic [XLEN-1:0] exp_dadr;
  logic [XLEN-1:0] exp_wd;
  int              cyc;
  int              acc_cnt [NCH];
  int              ack_cnt [NCH];
  int              checks;
  int              errors;

  task automatic chk(input string name, input logic [XLEN-1:0] act,
                     input logic [XLEN-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d actual=%h required=%h", name, cyc, act, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: acceptance, arbitration, memory contents, reset flush
  // ---------------------------------------------------------------------------
  initial begin
    int   last;
    int   next_acc;
    int   found;
    int   c;
    txn_t t;
    last     = NCH - 1;
    next_acc = 0;
    cyc      = 0;
    exp_dadr = '0;
    exp_wd   = '0;
    for (int i = 0; i < NCH; i++) acc_cnt[i] = 0;
    for (int i = 0; i < DEPTH; i++) mem_m[i] = '0;
    forever begin
      @(posedge clk or negedge reset);
      if (!reset) begin
        // An aborted write whose final edge has not happened leaves the
        // memory untouched.
        if (exp_q.size() > 0 && exp_q[0].w && cyc < exp_q[0].ackc)
          mem_m[exp_q[0].idx] = exp_q[0].old;
        exp_q.delete();
        last     = NCH - 1;
        next_acc = 0;
        exp_dadr = '0;
        exp_wd   = '0;
      end
      if (clk === 1'b1) begin
        cyc++;
        if (reset === 1'b1 && cyc >= next_acc) begin
          found = -1;
          for (int k = 1; k <= NCH; k++) begin
            c = (last + k) % NCH;
            if (req_v[c] && found < 0) found = c;
          end
          if (found >= 0) begin
            t.ch   = found;
            t.w    = we_v[found];
            t.a    = addr_ch[found];
            t.d    = wd_ch[found];
            t.idx  = int'((t.a >> 2) % DEPTH);
            t.old  = mem_m[t.idx];
            t.rd   = mem_m[t.idx];
            t.acc  = cyc;
            t.ackc = cyc + LAT;
            if (t.w) mem_m[t.idx] = t.d;
            exp_dadr = t.a;
            exp_wd   = t.d;
            exp_q.push_back(t);
            last     = found;
            next_acc = cyc + LAT + 2;
            acc_cnt[found]++;
          end
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Monitor: compares DUT outputs every cycle against the queue head
  // ---------------------------------------------------------------------------
  initial begin
    logic [XLEN-1:0] exp_rdata;
    logic [XLEN-1:0] exp_ack;
    logic            exp_busy;
    logic            exp_mw;
    logic            have;
    logic            done;
    txn_t            cur;
    exp_rdata = '0;
    forever begin
      @(negedge clk);
      if (!reset) exp_rdata = '0;
      exp_ack  = '0;
      exp_busy = 1'b0;
      exp_mw   = 1'b0;
      done     = 1'b0;
      have     = (exp_q.size() > 0);
      if (have) begin
        cur      = exp_q[0];
        exp_busy = (cyc >= cur.acc) && (cyc <= cur.ackc);
        exp_mw   = cur.w && (cyc == cur.ackc - 1);
        if (cyc == cur.ackc) begin
          exp_ack[cur.ch] = 1'b1;
          if (!cur.w) exp_rdata = cur.rd;
          done = 1'b1;
        end
      end
      chk("ack",       XLEN'(ack),      exp_ack);
      chk("busy",      XLEN'(busy),     XLEN'(exp_busy));
      chk("MemWrite",  XLEN'(MemWrite), XLEN'(exp_mw));
      chk("rdata",     rdata,           exp_rdata);
      chk("DataAdr",   DataAdr,         exp_dadr);
      chk("WriteData", WriteData,       exp_wd);
      if (done) begin
        $display("txn ch=%0d %s addr=%h data=%h rdata=%h acc=%0d ack=%0d",
                 cur.ch, cur.w ? "WR" : "RD", cur.a, cur.d, rdata,
                 cur.acc, cur.ackc);
        void'(exp_q.pop_front());
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  function automatic logic [XLEN-1:0] rand_addr();
    logic [XLEN-1:0] a;
    a = XLEN'($urandom);
    // Half the time, confine to a few words so reads hit recent writes.
    if ($urandom_range(0, 1) == 1) a[7:2] = 6'($urandom_range(0, 7));
    return a;
  endfunction

  task automatic do_txn(input int ch, input logic w, input logic [XLEN-1:0] a,
                        input logic [XLEN-1:0] d, input bit scramble,
                        output logic [XLEN-1:0] rd);
    bit got;
    @(negedge clk);
    req_v[ch]   = 1'b1;
    we_v[ch]    = w;
    addr_ch[ch] = a;
    wd_ch[ch]   = d;
    got         = 1'b0;
    rd          = '0;
    for (int n = 0; n < 40 && !got; n++) begin
      @(negedge clk);
      if (ack[ch]) begin
        got = 1'b1;
        rd  = rdata;
      end else if (scramble && busy) begin
        addr_ch[ch] = XLEN'($urandom);
        wd_ch[ch]   = XLEN'($urandom);
        we_v[ch]    = ~we_v[ch];
      end
    end
    req_v[ch] = 1'b0;
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL txn_timeout ch=%0d actual=no_ack required=ack", ch);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Main stimulus
  // ---------------------------------------------------------------------------
  initial begin
    logic [XLEN-1:0] rd;
    int              order [4];
    int              exp_order [4];
    int              nack;
    bit              pend [NCH];
    bit              drained;

    checks = 0;
    errors = 0;
    reset  = 1'b0;
    req_v  = '0;
    we_v   = '0;
    for (int i = 0; i < NCH; i++) begin
      addr_ch[i] = '0;
      wd_ch[i]   = '0;
      pend[i]    = 1'b0;
    end
    repeat (3) @(negedge clk);
    reset = 1'b1;
    // Idle after reset: the monitor expects everything quiet.
    repeat (10) @(negedge clk);

    // Give every word a known value.
    for (int w = 0; w < DEPTH; w++)
      do_txn(w % NCH, 1'b1, XLEN'(w * 4), XLEN'($urandom), 1'b0, rd);

    // Write then read back.
    do_txn(0, 1'b1, 32'h10, 32'hDEADBEEF, 1'b0, rd);
    do_txn(0, 1'b0, 32'h10, 32'h0, 1'b0, rd);
    chk("read_after_write", rd, 32'hDEADBEEF);

    // Read with the channel's inputs changing during ACCESS.
    do_txn(1, 1'b0, 32'h10, 32'h0, 1'b1, rd);
    chk("read_inputs_changed", rd, 32'hDEADBEEF);

    // Aliasing and ignored byte-offset bits.
    do_txn(0, 1'b1, 32'h000, 32'h55, 1'b0, rd);
    do_txn(1, 1'b0, 32'h100, 32'h0, 1'b0, rd);
    chk("alias_0x100", rd, 32'h55);
    do_txn(2, 1'b0, 32'h003, 32'h0, 1'b0, rd);
    chk("alias_0x003", rd, 32'h55);

    // Reset during ACCESS of a write: no ack, old contents survive.
    do_txn(0, 1'b1, 32'h20, 32'hCAFE0000, 1'b0, rd);
    @(negedge clk);
    req_v[0] = 1'b1; we_v[0] = 1'b1; addr_ch[0] = 32'h20; wd_ch[0] = 32'h1234;
    for (int n = 0; n < 20 && !busy; n++) @(negedge clk);
    @(negedge clk);
    #1;
    reset    = 1'b0;
    req_v[0] = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    do_txn(0, 1'b0, 32'h20, 32'h0, 1'b0, rd);
    chk("reset_abort_read", rd, 32'hCAFE0000);

    // Fresh reset, then ch0 and ch1 request together and hold.
    @(negedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      req_v[i] = 1'b1; we_v[i] = 1'($urandom_range(0, 1));
      addr_ch[i] = rand_addr(); wd_ch[i] = XLEN'($urandom);
    end
    nack = 0;
    for (int n = 0; n < 200 && nack < 4; n++) begin
      @(negedge clk);
      for (int i = 0; i < NCH; i++) begin
        if (ack[i] && nack < 4) begin
          order[nack] = i;
          nack++;
          we_v[i] = 1'($urandom_range(0, 1));
          addr_ch[i] = rand_addr(); wd_ch[i] = XLEN'($urandom);
        end
      end
    end
    req_v = '0;
    exp_order[0] = 0; exp_order[1] = 1; exp_order[2] = 0; exp_order[3] = 1;
    chk("rr_ack_count", XLEN'(nack), 32'd4);
    for (int k = 0; k < 4; k++)
      chk($sformatf("rr_order_%0d", k), XLEN'(order[k]), XLEN'(exp_order[k]));

    // Randomised traffic on all channels.
    for (int i = 0; i < NCH; i++) ack_cnt[i] = acc_cnt[i];
    for (int n = 0; n < 1500; n++) begin
      @(negedge clk);
      for (int i = 0; i < NCH; i++) begin
        if (ack[i]) begin
          pend[i]  = 1'b0;
          req_v[i] = 1'b0;
          ack_cnt[i]++;
        end
        if (!pend[i]) begin
          if ($urandom_range(0, 3) == 0) begin
            pend[i]    = 1'b1;
            req_v[i]   = 1'b1;
            we_v[i]    = 1'($urandom_range(0, 1));
            addr_ch[i] = rand_addr();
            wd_ch[i]   = XLEN'($urandom);
          end
        end else if (acc_cnt[i] > ack_cnt[i]) begin
          // Already accepted: fiddle with inputs, sometimes drop req early.
          if ($urandom_range(0, 3) == 0) begin
            addr_ch[i] = rand_addr();
            wd_ch[i]   = XLEN'($urandom);
            we_v[i]    = ~we_v[i];
          end
          if ($urandom_range(0, 7) == 0) req_v[i] = 1'b0;
        end
      end
    end
    req_v = '0;

    drained = 1'b0;
    for (int n = 0; n < 30 && !drained; n++) begin
      @(negedge clk);
      drained = (exp_q.size() == 0);
    end
    chk("drain_queue_empty", XLEN'(exp_q.size()), 32'd0);
    repeat (3) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
